// File: rtl/control_unit_if.sv
// Control-unit <-> datapath signal bundle: instruction/memory status in, control strobes out.
// Step exists only when STEP_EN is defined.
interface control_unit_if;
    logic [31:0] IR;
    logic        Mem_ready;
`ifdef STEP_EN
    logic        Step;
`endif
    logic PCout, Zlowout, MDRout;
    logic MARin, Zin, PCin, MDRin, IRin, Yin;
    logic IncPC, Read;
    logic Gra, Grb, Grc, Rin, Rout;
    logic ADD, SUB, AND, OR;
    logic Run, Illegal;

    modport master (
`ifdef STEP_EN
        input  Step,
`endif
        input  IR, Mem_ready,
        output PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
        output IncPC, Read, Gra, Grb, Grc, Rin, Rout, ADD, SUB, AND, OR,
        output Run, Illegal
    );

    modport slave (
`ifdef STEP_EN
        output Step,
`endif
        output IR, Mem_ready,
        input  PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
        input  IncPC, Read, Gra, Grb, Grc, Rin, Rout, ADD, SUB, AND, OR,
        input  Run, Illegal
    );
endinterface

// File: rtl/control_unit.sv
// Hardwired fetch/execute sequencer for a 3-register ALU instruction set.
// Define STEP_EN to add the PAUSE state and the Step single-step input.
module control_unit (
    input  logic            Clock,
    input  logic            Reset,
    control_unit_if.master  bus
);
    typedef enum logic [3:0] {
        IDLE, T0, T1, T2, T3, T4, T5, HALTED
`ifdef STEP_EN
        , PAUSE
`endif
    } state_t;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

`ifdef STEP_EN
    localparam state_t DONE = PAUSE;
`else
    localparam state_t DONE = T0;
`endif

    state_t     state;
    logic [4:0] opcode;
    logic       illegal;
    logic       t1_first;   // marks the first T1 cycle so PC loads once across memory waits
    logic [4:0] ir_op;
    logic       unused_ir;

    assign ir_op     = bus.IR[31:27];
    assign unused_ir = ^bus.IR[26:0];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= IDLE;
            opcode   <= '0;
            illegal  <= 1'b0;
            t1_first <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= T0;
                T0: begin
                    state    <= T1;
                    t1_first <= 1'b1;
                end
                T1: begin
                    t1_first <= 1'b0;
                    if (bus.Mem_ready) state <= T2;
                end
                T2: begin
                    case (ir_op)
                        OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                            opcode <= ir_op;
                            state  <= T3;
                        end
                        OP_NOP:  state <= DONE;
                        OP_HALT: state <= HALTED;
                        default: begin
                            illegal <= 1'b1;
                            state   <= DONE;
                        end
                    endcase
                end
                T3:     state <= T4;
                T4:     state <= T5;
                T5:     state <= DONE;
                HALTED: state <= HALTED;
`ifdef STEP_EN
                PAUSE:  if (bus.Step) state <= T0;
`endif
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Run     = (state != HALTED);
    assign bus.Illegal = illegal;

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        bus.PCout = 1'b0; bus.Zlowout = 1'b0; bus.MDRout = 1'b0;
        bus.MARin = 1'b0; bus.Zin = 1'b0; bus.PCin = 1'b0;
        bus.MDRin = 1'b0; bus.IRin = 1'b0; bus.Yin = 1'b0;
        bus.IncPC = 1'b0; bus.Read = 1'b0;
        bus.Gra = 1'b0; bus.Grb = 1'b0; bus.Grc = 1'b0;
        bus.Rin = 1'b0; bus.Rout = 1'b0;
        bus.ADD = 1'b0; bus.SUB = 1'b0; bus.AND = 1'b0; bus.OR = 1'b0;
        case (state)
            T0: begin
                bus.PCout = 1'b1; bus.MARin = 1'b1;
                bus.IncPC = 1'b1; bus.Zin   = 1'b1;
            end
            T1: begin
                bus.Zlowout = 1'b1; bus.Read  = 1'b1;
                bus.MDRin   = 1'b1; bus.PCin  = t1_first;
            end
            T2: begin
                bus.MDRout = 1'b1; bus.IRin = 1'b1;
            end
            T3: begin
                bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
            end
            T4: begin
                bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1;
                bus.ADD = (opcode == OP_ADD);
                bus.SUB = (opcode == OP_SUB);
                bus.AND = (opcode == OP_AND);
                bus.OR  = (opcode == OP_OR);
            end
            T5: begin
                bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
            end
            default: ;
        endcase
    end
endmodule
